// File: rtl/mu_bus_pkg.sv
// Shared definitions for the motion-update broadcast bus: FSM encoding,
// pipeline/settle timing and the {x,y,z} cell-id slot layout.
package mu_bus_pkg;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_RD_CNT    = 4'd1,
      ST_WAIT_CNT  = 4'd2,
      ST_STREAM    = 4'd3,
      ST_DRAIN     = 4'd4,
      ST_NEXT_CELL = 4'd5,
      ST_CLOSE     = 4'd6,
      ST_SETTLE    = 4'd7,
      ST_FIN       = 4'd8
   } mu_state_e;

   // Cache readout latency, and cycles from enable-fall to done.
   localparam int READ_LATENCY = 2;
   localparam int SWAP_SETTLE  = 3;

   // Slot index of each axis inside a packed {x,y,z} cell id.
   localparam int CELL_X_SLOT = 2;
   localparam int CELL_Y_SLOT = 1;
   localparam int CELL_Z_SLOT = 0;

endpackage

// File: rtl/mu_dst_cell_calc.sv
// One axis of the destination-cell computation: single periodic wrap of the
// integer cell field, then +1 to form a 1-based cell id. Purely combinational.
module mu_dst_cell_calc
   import mu_bus_pkg::*;
#(
   parameter int CELL_ID_WIDTH = 4,
   parameter int CELL_NUM      = 4
) (
   input  logic [CELL_ID_WIDTH-1:0] field,
   output logic [CELL_ID_WIDTH-1:0] dst
);

   localparam logic [CELL_ID_WIDTH:0] NUM_W = (CELL_ID_WIDTH+1)'(CELL_NUM);

   logic [CELL_ID_WIDTH-1:0] wrapped;

   always_comb begin
      wrapped = field;
      if ({1'b0, field} >= NUM_W) begin
         wrapped = field - NUM_W[CELL_ID_WIDTH-1:0];
      end
      dst = wrapped + CELL_ID_WIDTH'(1);
   end

endmodule

// File: rtl/motion_update_broadcaster.sv
// Source end of the motion-update bus: sweeps all cells x-major, streams each particle
// with its destination cell. MU_OOB_CHECK_EN adds out-of-range suppression and oob_err.
module motion_update_broadcaster
   import mu_bus_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 8,
   parameter int CELL_ID_WIDTH = 4,
   parameter int CELL_NUM_X    = 4,
   parameter int CELL_NUM_Y    = 4,
   parameter int CELL_NUM_Z    = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   output logic [3*CELL_ID_WIDTH-1:0] rd_cell_sel,
   output logic [ADDR_WIDTH-1:0]      rd_address,
   output logic                       rd_en,
   input  logic [3*DATA_WIDTH-1:0]    pos_rd_data,
   input  logic [3*DATA_WIDTH-1:0]    vel_rd_data,
   output logic                       motion_update_enable,
   output logic [3*DATA_WIDTH-1:0]    out_pos_data,
   output logic [3*DATA_WIDTH-1:0]    out_vel_data,
   output logic [3*CELL_ID_WIDTH-1:0] out_dst_cell,
   output logic                       out_data_valid,
   output logic                       busy,
   output logic                       done,
   output logic                       oob_err
);

   localparam int CW           = CELL_ID_WIDTH;
   localparam int DRAIN_CYCLES = READ_LATENCY + 1;

   mu_state_e               state_q, state_d;
   logic [1:0]              wait_q, wait_d;
   logic [ADDR_WIDTH-1:0]   count_q, count_d;
   logic [CW-1:0]           cx_q, cx_d, cy_q, cy_d, cz_q, cz_d;
   logic [3*CW-1:0]         rd_cell_sel_q, rd_cell_sel_d;
   logic [ADDR_WIDTH-1:0]   rd_address_q, rd_address_d;
   logic                    rd_en_q, rd_en_d, enable_q, enable_d;
   logic                    busy_q, busy_d, done_q, done_d;
   logic                    p1_q, p1_d, p2_q, p2_d;
   logic [3*DATA_WIDTH-1:0] out_pos_q, out_pos_d, out_vel_q, out_vel_d;
   logic [3*CW-1:0]         out_dst_q, out_dst_d;
   logic                    out_valid_q, out_valid_d, oob_err_q, oob_err_d;
   logic                    last_cell, oob_any;
   logic [CW-1:0]           fx, fy, fz, dx, dy, dz;

   // Readout layout is {z,y,x}; the cell field is the top bits of each coordinate.
   assign fx = pos_rd_data[DATA_WIDTH-1 -: CW];
   assign fy = pos_rd_data[2*DATA_WIDTH-1 -: CW];
   assign fz = pos_rd_data[3*DATA_WIDTH-1 -: CW];

   mu_dst_cell_calc #(.CELL_ID_WIDTH(CW), .CELL_NUM(CELL_NUM_X)) u_dst_x (.field(fx), .dst(dx));
   mu_dst_cell_calc #(.CELL_ID_WIDTH(CW), .CELL_NUM(CELL_NUM_Y)) u_dst_y (.field(fy), .dst(dy));
   mu_dst_cell_calc #(.CELL_ID_WIDTH(CW), .CELL_NUM(CELL_NUM_Z)) u_dst_z (.field(fz), .dst(dz));

`ifdef MU_OOB_CHECK_EN
   localparam logic [CW+1:0] LIM_X = (CW+2)'(2*CELL_NUM_X);
   localparam logic [CW+1:0] LIM_Y = (CW+2)'(2*CELL_NUM_Y);
   localparam logic [CW+1:0] LIM_Z = (CW+2)'(2*CELL_NUM_Z);
   assign oob_any = ({2'b00, fx} >= LIM_X) || ({2'b00, fy} >= LIM_Y) || ({2'b00, fz} >= LIM_Z);
`else
   assign oob_any = 1'b0;
`endif

   assign last_cell = (cx_q == CW'(CELL_NUM_X)) && (cy_q == CW'(CELL_NUM_Y)) &&
                      (cz_q == CW'(CELL_NUM_Z));

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      count_d   = count_q;
      cx_d      = cx_q;
      cy_d      = cy_q;
      cz_d      = cz_q;
      oob_err_d = oob_err_q;
      case (state_q)
         ST_IDLE: if (start) begin
            state_d   = ST_RD_CNT;
            cx_d      = CW'(1);
            cy_d      = CW'(1);
            cz_d      = CW'(1);
            oob_err_d = 1'b0;
         end
         ST_RD_CNT: begin
            state_d = ST_WAIT_CNT;
            wait_d  = '0;
         end
         ST_WAIT_CNT: if (wait_q == 2'(READ_LATENCY-1)) begin
            count_d = pos_rd_data[ADDR_WIDTH-1:0];
            state_d = (pos_rd_data[ADDR_WIDTH-1:0] == '0) ? ST_NEXT_CELL : ST_STREAM;
         end else begin
            wait_d = wait_q + 2'd1;
         end
         ST_STREAM: if (rd_address_q == count_q) begin
            state_d = ST_DRAIN;
            wait_d  = '0;
         end
         ST_DRAIN: if (wait_q == 2'(DRAIN_CYCLES-1)) begin
            state_d = ST_NEXT_CELL;
         end else begin
            wait_d = wait_q + 2'd1;
         end
         ST_NEXT_CELL: if (last_cell) begin
            state_d = ST_CLOSE;
            cx_d    = CW'(1);
            cy_d    = CW'(1);
            cz_d    = CW'(1);
         end else begin
            state_d = ST_RD_CNT;
            if (cz_q == CW'(CELL_NUM_Z)) begin
               cz_d = CW'(1);
               if (cy_q == CW'(CELL_NUM_Y)) begin
                  cy_d = CW'(1);
                  cx_d = cx_q + CW'(1);
               end else begin
                  cy_d = cy_q + CW'(1);
               end
            end else begin
               cz_d = cz_q + CW'(1);
            end
         end
         ST_CLOSE: begin
            state_d = ST_SETTLE;
            wait_d  = '0;
         end
         ST_SETTLE: if (wait_q == 2'(SWAP_SETTLE-2)) begin
            state_d = ST_FIN;
         end else begin
            wait_d = wait_q + 2'd1;
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (p2_q && oob_any) oob_err_d = 1'b1;

      // Outputs are decoded from the next state so they appear registered in that state.
      rd_en_d      = (state_d == ST_RD_CNT) || (state_d == ST_STREAM);
      rd_address_d = '0;
      if (state_d == ST_STREAM) begin
         rd_address_d = (state_q == ST_STREAM) ? rd_address_q + ADDR_WIDTH'(1) : ADDR_WIDTH'(1);
      end
      enable_d = state_d inside {ST_RD_CNT, ST_WAIT_CNT, ST_STREAM, ST_DRAIN, ST_NEXT_CELL};
      busy_d   = !(state_d inside {ST_IDLE, ST_FIN});
      done_d   = (state_d == ST_FIN);
      rd_cell_sel_d = '0;
      if (busy_d) begin
         rd_cell_sel_d[CELL_X_SLOT*CW +: CW] = cx_d;
         rd_cell_sel_d[CELL_Y_SLOT*CW +: CW] = cy_d;
         rd_cell_sel_d[CELL_Z_SLOT*CW +: CW] = cz_d;
      end

      // Only particle reads (address != 0) are tagged through the read latency.
      p1_d        = rd_en_q && (rd_address_q != '0);
      p2_d        = p1_q;
      out_valid_d = p2_q && !oob_any;
      out_pos_d   = p2_q ? pos_rd_data : out_pos_q;
      out_vel_d   = p2_q ? vel_rd_data : out_vel_q;
      out_dst_d   = out_dst_q;
      if (p2_q) begin
         out_dst_d[CELL_X_SLOT*CW +: CW] = dx;
         out_dst_d[CELL_Y_SLOT*CW +: CW] = dy;
         out_dst_d[CELL_Z_SLOT*CW +: CW] = dz;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         wait_q        <= '0;
         count_q       <= '0;
         cx_q          <= CW'(1);
         cy_q          <= CW'(1);
         cz_q          <= CW'(1);
         rd_cell_sel_q <= '0;
         rd_address_q  <= '0;
         rd_en_q       <= 1'b0;
         enable_q      <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         p1_q          <= 1'b0;
         p2_q          <= 1'b0;
         out_pos_q     <= '0;
         out_vel_q     <= '0;
         out_dst_q     <= '0;
         out_valid_q   <= 1'b0;
         oob_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_q        <= wait_d;
         count_q       <= count_d;
         cx_q          <= cx_d;
         cy_q          <= cy_d;
         cz_q          <= cz_d;
         rd_cell_sel_q <= rd_cell_sel_d;
         rd_address_q  <= rd_address_d;
         rd_en_q       <= rd_en_d;
         enable_q      <= enable_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         p1_q          <= p1_d;
         p2_q          <= p2_d;
         out_pos_q     <= out_pos_d;
         out_vel_q     <= out_vel_d;
         out_dst_q     <= out_dst_d;
         out_valid_q   <= out_valid_d;
         oob_err_q     <= oob_err_d;
      end
   end

   assign rd_cell_sel          = rd_cell_sel_q;
   assign rd_address           = rd_address_q;
   assign rd_en                = rd_en_q;
   assign motion_update_enable = enable_q;
   assign out_pos_data         = out_pos_q;
   assign out_vel_data         = out_vel_q;
   assign out_dst_cell         = out_dst_q;
   assign out_data_valid       = out_valid_q;
   assign busy                 = busy_q;
   assign done                 = done_q;
   assign oob_err              = oob_err_q;

endmodule

// File: tb/tb_motion_update_broadcaster.sv
// Bench for motion_update_broadcaster: cell-cache memory model with 2-cycle readout,
// broadcast monitor, and a per-sweep expected list built from the cell contents.
module tb_motion_update_broadcaster;

   localparam int DW    = 32;
   localparam int AW    = 8;
   localparam int CW    = 4;
   localparam int NX    = 4;
   localparam int NY    = 4;
   localparam int NZ    = 4;
   localparam int NCELL = NX * NY * NZ;
   localparam int MAXP  = 8;
   localparam int EW    = 6 * DW + 3 * CW;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [3*CW-1:0] rd_cell_sel;
   logic [AW-1:0]   rd_address;
   logic            rd_en;
   logic [3*DW-1:0] pos_rd_data = '0;
   logic [3*DW-1:0] vel_rd_data = '0;
   logic            motion_update_enable;
   logic [3*DW-1:0] out_pos_data;
   logic [3*DW-1:0] out_vel_data;
   logic [3*CW-1:0] out_dst_cell;
   logic            out_data_valid;
   logic            busy;
   logic            done;
   logic            oob_err;

   motion_update_broadcaster #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CELL_ID_WIDTH(CW),
      .CELL_NUM_X(NX), .CELL_NUM_Y(NY), .CELL_NUM_Z(NZ)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .rd_cell_sel(rd_cell_sel), .rd_address(rd_address), .rd_en(rd_en),
      .pos_rd_data(pos_rd_data), .vel_rd_data(vel_rd_data),
      .motion_update_enable(motion_update_enable),
      .out_pos_data(out_pos_data), .out_vel_data(out_vel_data),
      .out_dst_cell(out_dst_cell), .out_data_valid(out_data_valid),
      .busy(busy), .done(done), .oob_err(oob_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- cell cache model ----------------
   int              cnt [NCELL];
   logic [3*DW-1:0] pos_mem [NCELL][MAXP];
   logic [3*DW-1:0] vel_mem [NCELL][MAXP];
   logic [3*DW-1:0] m1_pos = '0;
   logic [3*DW-1:0] m1_vel = '0;

   function automatic int cell_idx(input logic [3*CW-1:0] sel);
      int x, y, z;
      x = int'(sel[11:8]);
      y = int'(sel[7:4]);
      z = int'(sel[3:0]);
      if (x < 1 || x > NX || y < 1 || y > NY || z < 1 || z > NZ) return -1;
      return (x - 1) * NY * NZ + (y - 1) * NZ + (z - 1);
   endfunction

   always @(posedge clk) begin : mem_model
      int ci;
      if (rd_en) begin
         ci = cell_idx(rd_cell_sel);
         if (ci >= 0 && int'(rd_address) < MAXP) begin
            m1_pos <= pos_mem[ci][rd_address];
            m1_vel <= vel_mem[ci][rd_address];
         end else begin
            m1_pos <= '0;
            m1_vel <= '0;
         end
      end
      pos_rd_data <= m1_pos;
      vel_rd_data <= m1_vel;
   end

   // ---------------- monitor ----------------
   logic [EW-1:0] obs_q[$];
   logic [EW-1:0] exp_q[$];
   logic          exp_oob;
   int done_cnt = 0, cnt_reads = 0, valid_wo_en = 0;
   int en_fall_cyc = 0, done_cyc = 0, busy_at_done = 0;
   logic en_prev = 1'b0;

   always @(negedge clk) begin
      if (out_data_valid) begin
         obs_q.push_back({out_pos_data, out_vel_data, out_dst_cell});
         if (!motion_update_enable) valid_wo_en++;
      end
      if (en_prev && !motion_update_enable) en_fall_cyc = cyc;
      en_prev = motion_update_enable;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         if (busy) busy_at_done++;
      end
      if (rd_en && rd_address == '0) cnt_reads++;
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk_coord(input int field);
      logic [DW-1:0] c;
      c = $urandom;
      c[DW-1 -: CW] = CW'(field);
      return c;
   endfunction

   task automatic set_count(input int c, input int n);
      logic [3*DW-1:0] w;
      w = {$urandom, $urandom, $urandom};
      w[AW-1:0] = AW'(n);
      cnt[c] = n;
      pos_mem[c][0] = w;
      vel_mem[c][0] = {$urandom, $urandom, $urandom};
   endtask

   task automatic set_particle(input int c, input int a, input int fx, input int fy, input int fz);
      pos_mem[c][a] = {mk_coord(fz), mk_coord(fy), mk_coord(fx)};
      vel_mem[c][a] = {$urandom, $urandom, $urandom};
   endtask

   task automatic clear_mem();
      for (int c = 0; c < NCELL; c++) begin
         set_count(c, 0);
         for (int a = 1; a < MAXP; a++) set_particle(c, a, 0, 0, 0);
      end
   endtask

   // Destination id from the rule: single periodic wrap, then 1-based.
   function automatic int ref_dst(input int field, input int n);
      int v;
      v = field;
      if (v >= n) v = v - n;
      return v + 1;
   endfunction

   task automatic build_expected();
      exp_q.delete();
      exp_oob = 1'b0;
      for (int x = 0; x < NX; x++)
         for (int y = 0; y < NY; y++)
            for (int z = 0; z < NZ; z++) begin
               int c;
               c = x * NY * NZ + y * NZ + z;
               for (int a = 1; a <= cnt[c]; a++) begin
                  logic [3*DW-1:0] p;
                  int fx, fy, fz;
                  p  = pos_mem[c][a];
                  fx = int'(p[DW-1 -: CW]);
                  fy = int'(p[2*DW-1 -: CW]);
                  fz = int'(p[3*DW-1 -: CW]);
`ifdef MU_OOB_CHECK_EN
                  if (fx >= 2 * NX || fy >= 2 * NY || fz >= 2 * NZ) begin
                     exp_oob = 1'b1;
                     continue;
                  end
`endif
                  exp_q.push_back({p, vel_mem[c][a], CW'(ref_dst(fx, NX)),
                                   CW'(ref_dst(fy, NY)), CW'(ref_dst(fz, NZ))});
               end
            end
   endtask

   task automatic run_sweep(input string tag, input int mid_start_at);
      int d0, r0, v0, n;
      bit got;
      build_expected();
      obs_q.delete();
      d0 = done_cnt;
      r0 = cnt_reads;
      v0 = valid_wo_en;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check({tag, "_busy_after_start"}, busy, 1);
      check({tag, "_oob_clr_on_start"}, oob_err, 0);
      if (mid_start_at > 0) begin
         repeat (mid_start_at) @(posedge clk);
         #1 start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
      end
      got = 1'b0;
      for (int i = 0; i < 4000 && !got; i++) begin
         @(negedge clk); #1;
         if (done_cnt != d0) got = 1'b1;
      end
      check({tag, "_done_seen"}, got, 1);
      repeat (20) @(negedge clk);
      #1;
      check({tag, "_done_count"}, done_cnt - d0, 1);
      check({tag, "_done_after_en_fall"}, done_cyc - en_fall_cyc, 3);
      check({tag, "_busy_low_at_done"}, busy_at_done, 0);
      check({tag, "_count_reads"}, cnt_reads - r0, NCELL);
      check({tag, "_valid_wo_enable"}, valid_wo_en - v0, 0);
      check({tag, "_bcast_count"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check({tag, "_bcast"}, obs_q[i], exp_q[i]);
      check({tag, "_oob_err"}, oob_err, exp_oob);
      check({tag, "_idle_busy"}, busy, 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int c, k, n;
      bit got;
      clear_mem();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk); #1;
      check("rst_enable", motion_update_enable, 0);
      check("rst_valid", out_data_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rd_en", rd_en, 0);
      check("rst_rd_address", rd_address, 0);
      check("rst_rd_cell_sel", rd_cell_sel, 0);
      check("rst_oob_err", oob_err, 0);
      check("rst_out_pos", out_pos_data, 0);
      check("rst_out_dst", out_dst_cell, 0);

      // Cell (1,1,1) with x fields 0,1,3 -> dst x 1,2,4
      clear_mem();
      set_count(0, 3);
      set_particle(0, 1, 0, $urandom_range(0, 3), $urandom_range(0, 3));
      set_particle(0, 2, 1, $urandom_range(0, 3), $urandom_range(0, 3));
      set_particle(0, 3, 3, $urandom_range(0, 3), $urandom_range(0, 3));
      run_sweep("cell111", 0);
      if (obs_q.size() >= 3) begin
         check("cell111_dstx0", obs_q[0][11:8], 1);
         check("cell111_dstx1", obs_q[1][11:8], 2);
         check("cell111_dstx2", obs_q[2][11:8], 4);
      end

      // x field 5 wraps once to dst x 2
      clear_mem();
      set_count(39, 1);
      set_particle(39, 1, 5, 2, 7);
      run_sweep("wrap5", 0);
      if (obs_q.size() >= 1) check("wrap5_dstx", obs_q[0][11:8], 2);

      clear_mem();
      run_sweep("empty", 0);

      // Random occupancy, with a start pulse landing mid-sweep
      clear_mem();
      for (int i = 0; i < 12; i++) begin
         c = $urandom_range(0, NCELL - 1);
         n = $urandom_range(1, MAXP - 1);
         set_count(c, n);
         for (int a = 1; a <= n; a++)
            set_particle(c, a, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      end
      run_sweep("random_midstart", 60);

      // Field 9: beyond one wrap (suppressed only with the range check built in)
      clear_mem();
      set_count(22, 2);
      set_particle(22, 1, 9, 1, 2);
      set_particle(22, 2, 3, 6, 0);
      run_sweep("field9", 0);
      clear_mem();
      set_count(63, 1);
      set_particle(63, 1, 2, 2, 2);
      run_sweep("after_field9", 0);

      // Reset during STREAM
      clear_mem();
      set_count(5, 6);
      for (int a = 1; a <= 6; a++) set_particle(5, a, a, a, a);
      k = done_cnt;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 500 && !got; i++) begin
         @(negedge clk); #1;
         if (rd_en && rd_address != '0) got = 1'b1;
      end
      check("rststream_reached", got, 1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      check("rststream_enable", motion_update_enable, 0);
      check("rststream_valid", out_data_valid, 0);
      check("rststream_busy", busy, 0);
      rst = 1'b0;
      repeat (300) @(negedge clk);
      #1;
      check("rststream_no_done", done_cnt - k, 0);
      check("rststream_idle", busy, 0);

      // Recovery sweep after the reset
      clear_mem();
      for (int i = 0; i < 6; i++) begin
         c = $urandom_range(0, NCELL - 1);
         n = $urandom_range(1, MAXP - 1);
         set_count(c, n);
         for (int a = 1; a <= n; a++)
            set_particle(c, a, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      end
      run_sweep("recover", 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
